// File: rtl/sub_sched_pkg.sv
// Shared constants, ID-width helper and response record for the round-robin
// subtract scheduler.
package sub_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Ceiling log2; a 1-entry pool still gets a 1-bit ID.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int ID_W_DEF = clog2(N_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [WIDTH_DEF-1:0] diff;
    logic                 overflow;
  } rsp_t;

endpackage

// File: rtl/sub_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
  import sub_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = clog2(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    idx      = 0;
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    // Scan backwards so the closest index to ptr is the last one written.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (req_i[idx]) begin
        winner_o = ID_W'(idx);
        any_o    = 1'b1;
      end
    end
    if (any_o) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/sub_rr_scheduler.sv
// Round-robin front end sharing one subtract/overflow unit among N_REQ
// requesters, with a single registered response slot and a debug op counter.
module sub_rr_scheduler
  import sub_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = clog2(N_REQ_DEF),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_diff,
  output logic                   rsp_overflow,
  output logic [CNT_W-1:0]       op_count
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_diff_q, rsp_diff_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic             slot_free;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] a_w, b_w, diff_w;
  logic             ovf_w;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // The slot can take a new result whenever it is empty or being drained now.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = slot_free && any_req;
  assign drain     = rsp_valid_q && rsp_ready;
  assign req_ready = slot_free ? grant : '0;

  assign a_w    = req_a[int'(winner)*WIDTH +: WIDTH];
  assign b_w    = req_b[int'(winner)*WIDTH +: WIDTH];
  assign diff_w = a_w - b_w;
  assign ovf_w  = (a_w[WIDTH-1] != b_w[WIDTH-1]) && (diff_w[WIDTH-1] != a_w[WIDTH-1]);

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_diff_d  = rsp_diff_q;
    rsp_ovf_d   = rsp_ovf_q;
    cnt_d       = cnt_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = winner;
      rsp_diff_d  = diff_w;
      rsp_ovf_d   = ovf_w;
      ptr_d       = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (drain) begin
      rsp_valid_d = 1'b0;
    end

    if (drain && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_diff_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_diff_q  <= rsp_diff_d;
      rsp_ovf_q   <= rsp_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_diff     = rsp_diff_q;
  assign rsp_overflow = rsp_ovf_q;
  assign op_count     = cnt_q;

endmodule

// File: doc/sub_rr_scheduler.md
Name: sub_rr_scheduler

Overview:
- Shares one 8-bit two's-complement subtract unit (diff = a - b, signed overflow flag) between N_REQ independent requesters.
- Round-robin arbitration with per-requester valid/ready handshakes.
- One registered response channel carrying the winner's ID; one-cycle latency from accept to response.
- Sits between issuing engines and the shared arithmetic resource; also keeps a saturating completed-operation counter for debug.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, 2, width of requester ID; must equal clog2(N_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; bit i high = requester i's operands taken this cycle.
- req_a  in  N_REQ*WIDTH  minuend, requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  subtrahend, same packing.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_diff  out  WIDTH  a - b, modulo 2^WIDTH.
- rsp_overflow  out  1  signed overflow of a - b.
- op_count  out  CNT_W  responses consumed since reset (rsp_valid & rsp_ready), saturating at all-ones.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_overflow=0, op_count=0, round-robin pointer ptr=0. Reset mid-operation drops any held response; in-flight handshakes are void.
- slot_free = !rsp_valid | rsp_ready (combinational).
- Arbitration (combinational): scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ); winner = first index with req_valid set.
- req_ready[winner] = slot_free; every other req_ready bit = 0. No valid requester -> all req_ready = 0.
- req_ready depends combinationally on req_valid and rsp_ready; requesters must not make req_valid depend on req_ready.
- Accept = slot_free & any req_valid. On the accepting edge:
  - rsp_diff <= a_w - b_w (WIDTH bits, borrow discarded).
  - rsp_overflow <= (a_w[MSB] != b_w[MSB]) & (diff[MSB] != a_w[MSB]).
  - rsp_id <= winner, rsp_valid <= 1, ptr <= (winner+1) mod N_REQ.
- Drain without new accept (rsp_valid & rsp_ready & no req_valid): rsp_valid <= 0; data fields hold their last values.
- Simultaneous drain and accept: the new result replaces the old in the same cycle; rsp_valid stays 1. Sustained throughput is one op/cycle.
- Backpressure (rsp_valid & !rsp_ready): all req_ready = 0; rsp_* held stable; ptr unchanged.
- ptr advances only on an accepted grant, never on idle cycles.
- op_count increments on each rsp_valid & rsp_ready cycle; it holds at 2^CNT_W - 1.
- Latency: result visible one cycle after the accept edge.

Decomposition:
- Package sub_sched_pkg holds: default WIDTH/N_REQ/CNT_W constants, a clog2 function for ID_W, and a typedef for the response struct {id, diff, overflow}.
- Sub-module rr_pick: N_REQ-bit request vector plus ptr in; one-hot grant plus encoded winner out; purely combinational.
- Subtract and overflow logic stays inline in sub_rr_scheduler.

Test Plan:
- Single op: req 0 valid, a=8'h50, b=8'h30, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_diff=8'h20, rsp_overflow=0; op_count=1 after the drain.
- Overflow and wrap:
  - a=8'h80, b=8'h01 -> diff=8'h7F, overflow=1.
  - a=8'h7F, b=8'hFF -> diff=8'h80, overflow=1.
  - a=8'h00, b=8'h01 -> diff=8'hFF, overflow=0.
- Fairness: all 4 requesters held valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one grant per cycle.
- Pointer skip: ptr=2, only req 1 and req 3 valid -> req 3 granted first, then req 1; ptr ends at 2.
- Backpressure: rsp_ready=0 for 3 cycles with result 8'h20 held -> all req_ready=0, rsp_* stable, ptr unchanged; rsp_ready=1 -> same-cycle drain and accept of the next winner.
- Reset mid-op: assert rst between edges while rsp_valid=1 -> rsp_valid=0 and op_count=0 without waiting for a clock edge; after release, first grant goes to requester 0 when all are valid.
